// File: rtl/icu_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : icu_sequencer_pkg
// Description : Shared ICU opcode and sequencer state types.
// Revision    : 1.0 - initial release
// ============================================================================
package icu_sequencer_pkg;

    typedef enum logic [3:0] {
        NOPO = 4'd0,
        LD   = 4'd1,
        LDC  = 4'd2,
        AND  = 4'd3,
        ANDC = 4'd4,
        OR   = 4'd5,
        ORC  = 4'd6,
        XNOR = 4'd7,
        STO  = 4'd8,
        STOC = 4'd9,
        IEN  = 4'd10,
        OEN  = 4'd11,
        JMP  = 4'd12,
        RTN  = 4'd13,
        SKZ  = 4'd14,
        NOPF = 4'd15
    } instruction_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2,
        STEP   = 2'd3
    } seq_state_t;

    localparam int c_opcode_w = 4;

endpackage
`default_nettype wire

// File: rtl/icu_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : icu_sequencer_if
// Description : Program-memory / ICU / control bundle of the sequencer.
//               SINGLE_STEP_EN adds the step_i control line.
// Revision    : 1.0 - initial release
// ============================================================================
interface icu_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int IO_W   = 3
) ();
    import icu_sequencer_pkg::*;

    logic                         start_i;
    logic                         stop_i;
`ifdef SINGLE_STEP_EN
    logic                         step_i;
`endif
    logic [ADDR_W-1:0]            prog_addr_o;
    logic [c_opcode_w+ADDR_W-1:0] prog_data_i;
    instruction_t                 instruction_o;
    logic [IO_W-1:0]              io_addr_o;
    logic                         jmp_i;
    logic                         rtn_i;
    logic                         flag_o_i;
    logic                         flag_f_i;
    logic                         running_o;
    logic                         halted_o;
    logic                         sync_o;
    logic                         stack_err_o;

    modport master (
`ifdef SINGLE_STEP_EN
        input  step_i,
`endif
        input  start_i, stop_i, prog_data_i, jmp_i, rtn_i, flag_o_i, flag_f_i,
        output prog_addr_o, instruction_o, io_addr_o,
        output running_o, halted_o, sync_o, stack_err_o
    );

    modport slave (
`ifdef SINGLE_STEP_EN
        output step_i,
`endif
        output start_i, stop_i, prog_data_i, jmp_i, rtn_i, flag_o_i, flag_f_i,
        input  prog_addr_o, instruction_o, io_addr_o,
        input  running_o, halted_o, sync_o, stack_err_o
    );

endinterface
`default_nettype wire

// File: rtl/icu_sequencer_return_stack.sv
`default_nettype none
// ============================================================================
// Module      : icu_sequencer_return_stack
// Description : LIFO of return addresses with a registered stack pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module icu_sequencer_return_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             push,
    input  wire logic             pop,
    input  wire logic [WIDTH-1:0] din,
    output logic      [WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty
);
    localparam int c_idx_w = $clog2(DEPTH);

    logic [c_idx_w:0]   r_sp;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_idx_w-1:0] w_wr_idx;
    logic [c_idx_w-1:0] w_rd_idx;

    // With DEPTH a power of two the low pointer bits wrap to the top slot.
    assign w_wr_idx = r_sp[c_idx_w-1:0];
    assign w_rd_idx = w_wr_idx - c_idx_w'(1);
    assign full     = (r_sp == (c_idx_w+1)'(DEPTH));
    assign empty    = (r_sp == '0);
    assign dout     = r_mem[w_rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sp <= '0;
        end else if (push && !full) begin
            r_sp <= r_sp + (c_idx_w+1)'(1);
        end else if (pop && !empty) begin
            r_sp <= r_sp - (c_idx_w+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            r_mem[w_wr_idx] <= din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/icu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : icu_sequencer
// Description : PC, fetch and call/return sequencing for the 1-bit ICU.
//               Optional macro SINGLE_STEP_EN adds step_i and a STEP state.
// Revision    : 1.0 - initial release
// ============================================================================
module icu_sequencer
    import icu_sequencer_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int IO_W        = 3,
    parameter int STACK_DEPTH = 4
) (
    input wire logic      clk,
    input wire logic      rst_n,
    icu_sequencer_if.master bus
);
    seq_state_t        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic              r_sync;
    logic              r_err;

    instruction_t      w_opcode;
    logic [ADDR_W-1:0] w_operand;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_ret_addr;
    logic              w_exec;
    logic              w_step_level;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_stack_err;

    assign w_opcode  = instruction_t'(bus.prog_data_i[c_opcode_w+ADDR_W-1:ADDR_W]);
    assign w_operand = bus.prog_data_i[ADDR_W-1:0];
    assign w_pc_inc  = r_pc + ADDR_W'(1);

`ifdef SINGLE_STEP_EN
    logic r_step_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step_q <= 1'b0;
        end else begin
            r_step_q <= bus.step_i;
        end
    end

    assign w_step_level = bus.step_i;
    assign w_exec = (r_state == RUN) ||
                    ((r_state == STEP) && bus.step_i && !r_step_q);
`else
    assign w_step_level = 1'b0;
    assign w_exec       = (r_state == RUN);
`endif

    // JMP outranks RTN; overflowing pushes and underflowing pops are dropped.
    assign w_push      = w_exec && bus.jmp_i && !w_full;
    assign w_pop       = w_exec && !bus.jmp_i && bus.rtn_i && !w_empty;
    assign w_stack_err = w_exec && ((bus.jmp_i && w_full) ||
                                    (!bus.jmp_i && bus.rtn_i && w_empty));

    icu_sequencer_return_stack #(
        .WIDTH (ADDR_W),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_pc_inc),
        .dout  (w_ret_addr),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_pc    <= '0;
            r_sync  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_sync <= w_exec && bus.flag_o_i;
            if (w_stack_err) begin
                r_err <= 1'b1;
            end
            if (w_exec) begin
                if (bus.jmp_i) begin
                    r_pc <= w_operand;
                end else if (bus.rtn_i) begin
                    r_pc <= w_empty ? '0 : w_ret_addr;
                end else begin
                    r_pc <= w_pc_inc;
                end
            end
            case (r_state)
                IDLE, HALTED: begin
                    if (bus.start_i && !bus.stop_i) begin
                        r_state <= w_step_level ? STEP : RUN;
                    end
                end
                RUN: begin
                    if (bus.stop_i || bus.flag_f_i) begin
                        r_state <= HALTED;
                    end
                end
                STEP: begin
                    if (bus.stop_i || (w_exec && bus.flag_f_i)) begin
                        r_state <= HALTED;
                    end else if (bus.start_i && !w_step_level) begin
                        r_state <= RUN;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.prog_addr_o   = r_pc;
    assign bus.instruction_o = w_exec ? w_opcode : NOPO;
    assign bus.io_addr_o     = w_exec ? w_operand[IO_W-1:0] : '0;
    assign bus.running_o     = (r_state == RUN);
    assign bus.halted_o      = (r_state == HALTED);
    assign bus.sync_o        = r_sync;
    assign bus.stack_err_o   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_icu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_icu_sequencer
// Description : Self-checking bench with a behavioural ROM and ICU decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icu_sequencer;
    import icu_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    logic [11:0] rom [256];

    typedef struct {
        logic [7:0] pc;
        logic       run;
        logic       halt;
        logic       sync;
        logic       err;
    } exp_t;

    typedef struct {
        logic       start;
        logic       stop;
        logic [7:0] pc;
        logic       run;
        logic       halt;
        logic       sync;
    } vec_t;

    exp_t sbq[$];

    icu_sequencer_if #(.ADDR_W(8), .IO_W(3)) bus ();

    icu_sequencer #(.ADDR_W(8), .IO_W(3), .STACK_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Combinational program ROM and ICU strobe decode.
    assign bus.prog_data_i = rom[bus.prog_addr_o];
    assign bus.jmp_i       = (bus.instruction_o == JMP);
    assign bus.rtn_i       = (bus.instruction_o == RTN);
    assign bus.flag_o_i    = (bus.instruction_o == NOPO);
    assign bus.flag_f_i    = (bus.instruction_o == NOPF);

    function automatic logic [11:0] word(input instruction_t op, input logic [7:0] a);
        return {op, a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load_default();
        for (int i = 0; i < 256; i++) rom[i] = word(LD, 8'(i));
    endtask

    task automatic compare(input exp_t e);
        logic [11:0] w;
        w = rom[e.pc];
        chk("pc", 32'(bus.prog_addr_o), 32'(e.pc));
        chk("instr", 32'(bus.instruction_o), e.run ? 32'(w[11:8]) : 32'(NOPO));
        chk("io_addr", 32'(bus.io_addr_o), e.run ? 32'(w[2:0]) : 32'd0);
        chk("running", 32'(bus.running_o), 32'(e.run));
        chk("halted", 32'(bus.halted_o), 32'(e.halt));
        chk("sync", 32'(bus.sync_o), 32'(e.sync));
        chk("stack_err", 32'(bus.stack_err_o), 32'(e.err));
    endtask

    // One cycle: drive controls, queue the expectation, compare once settled.
    task automatic step(input logic st, input logic sp, input logic [7:0] pc,
                        input logic run, input logic halt, input logic sync,
                        input logic err);
        exp_t e;
        @(posedge clk);
        #1;
        bus.start_i = st;
        bus.stop_i  = sp;
        e.pc = pc; e.run = run; e.halt = halt; e.sync = sync; e.err = err;
        sbq.push_back(e);
        #1;
        if (sbq.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            compare(sbq.pop_front());
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pc"}, 32'(bus.prog_addr_o), 32'd0);
        chk({tag, "_instr"}, 32'(bus.instruction_o), 32'(NOPO));
        chk({tag, "_io"}, 32'(bus.io_addr_o), 32'd0);
        chk({tag, "_running"}, 32'(bus.running_o), 32'd0);
        chk({tag, "_halted"}, 32'(bus.halted_o), 32'd0);
        chk({tag, "_sync"}, 32'(bus.sync_o), 32'd0);
        chk({tag, "_err"}, 32'(bus.stack_err_o), 32'd0);
    endtask

    task automatic do_reset();
        bus.start_i = 1'b0;
        bus.stop_i  = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t vecs [18];

    initial begin
        bus.start_i = 1'b0;
        bus.stop_i  = 1'b0;
`ifdef SINGLE_STEP_EN
        bus.step_i  = 1'b0;
`endif
        load_default();

        // Main program: LD run, NOPO sync, call/return, NOPF halt, resume, stop.
        rom[8'h03] = word(NOPO, 8'h03);
        rom[8'h05] = word(JMP,  8'h40);
        rom[8'h40] = word(RTN,  8'h00);
        rom[8'h07] = word(JMP,  8'h10);
        rom[8'h10] = word(NOPF, 8'h00);
        rom[8'h12] = word(RTN,  8'h00);
        vecs = '{
            '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0},
            '{1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0},
            '{1'b0, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0},
            '{1'b0, 1'b0, 8'h03, 1'b1, 1'b0, 1'b0},
            '{1'b0, 1'b0, 8'h04, 1'b1, 1'b0, 1'b1},
            '{1'b0, 1'b0, 8'h05, 1'b1, 1'b0, 1'b0},
            '{1'b0, 1'b0, 8'h40, 1'b1, 1'b0, 1'b0},
            '{1'b0, 1'b0, 8'h06, 1'b1, 1'b0, 1'b0},
            '{1'b0, 1'b0, 8'h07, 1'b1, 1'b0, 1'b0},
            '{1'b0, 1'b0, 8'h10, 1'b1, 1'b0, 1'b0},
            '{1'b0, 1'b0, 8'h11, 1'b0, 1'b1, 1'b0},
            '{1'b1, 1'b0, 8'h11, 1'b0, 1'b1, 1'b0},
            '{1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0},
            '{1'b0, 1'b0, 8'h12, 1'b1, 1'b0, 1'b0},
            '{1'b0, 1'b0, 8'h08, 1'b1, 1'b0, 1'b0},
            '{1'b0, 1'b1, 8'h09, 1'b1, 1'b0, 1'b0},
            '{1'b0, 1'b0, 8'h0A, 1'b0, 1'b1, 1'b0}
        };
        do_reset();
        for (int i = 0; i < 18; i++) begin
            step(vecs[i].start, vecs[i].stop, vecs[i].pc,
                 vecs[i].run, vecs[i].halt, vecs[i].sync, 1'b0);
        end

        // Overflow on the fifth nested call, unwind, then underflow to 0.
        load_default();
        rom[8'h00] = word(JMP, 8'h20);
        rom[8'h20] = word(JMP, 8'h30);
        rom[8'h30] = word(JMP, 8'h50);
        rom[8'h50] = word(JMP, 8'h60);
        rom[8'h60] = word(JMP, 8'h70);
        rom[8'h70] = word(RTN, 8'h00);
        rom[8'h51] = word(RTN, 8'h00);
        rom[8'h31] = word(RTN, 8'h00);
        rom[8'h21] = word(RTN, 8'h00);
        rom[8'h01] = word(RTN, 8'h00);
        do_reset();
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h20, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h30, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h50, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h60, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h70, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 8'h51, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 8'h31, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 8'h21, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 8'h20, 1'b0, 1'b1, 1'b0, 1'b1);

        // PC wraps from 0xFF to 0x00.
        load_default();
        rom[8'h00] = word(JMP, 8'hFE);
        do_reset();
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'hFE, 1'b0, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset mid-run at PC 0x22 with two stacked returns.
        load_default();
        rom[8'h00] = word(JMP, 8'h10);
        rom[8'h10] = word(JMP, 8'h20);
        do_reset();
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h20, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h21, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        // An RTN right after reset must underflow if the stack was cleared.
        rom[8'h00] = word(RTN, 8'h00);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);

`ifdef SINGLE_STEP_EN
        // Three step pulses advance the PC by exactly three.
        load_default();
        do_reset();
        @(posedge clk); #1;
        bus.step_i  = 1'b1;
        bus.start_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        bus.step_i  = 1'b0;
        for (int p = 0; p < 3; p++) begin
            @(posedge clk); #1;
            #1;
            chk("step_idle_instr", 32'(bus.instruction_o), 32'(NOPO));
            bus.step_i = 1'b1;
            #1;
            chk("step_exec_instr", 32'(bus.instruction_o), 32'(LD));
            @(posedge clk); #1;
            bus.step_i = 1'b0;
        end
        @(posedge clk); #2;
        chk("step_pc", 32'(bus.prog_addr_o), 32'd3);
        chk("step_running", 32'(bus.running_o), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/icu_sequencer.md
Name: icu_sequencer

Overview:
- Program sequencer for the 1-bit ICU: owns the program counter, fetches program words from an external combinational program ROM, and feeds opcodes plus I/O addresses to the ICU.
- Reacts to the ICU's decoded strobes (jmp, rtn, flag_f, flag_o) to implement call/return via a hardware return stack, halt-on-NOPF and a sync pulse.
- Sits between program memory and the ICU at the top level.

Parameters:
- ADDR_W, 8, program address width; PC wraps modulo 2^ADDR_W.
- IO_W, 3, I/O select width; taken from the low IO_W bits of the operand field (IO_W <= ADDR_W).
- STACK_DEPTH, 4, return-stack entries (power of 2, >= 2).

Ports:
- clk  in  1  system clock; all sequencer state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- start_i  in  1  level; leaves IDLE/HALTED on a posedge where it is high.
- stop_i  in  1  level; forces HALTED from RUN.
- prog_addr_o  out  ADDR_W  = PC.
- prog_data_i  in  4+ADDR_W  {opcode[3:0], operand[ADDR_W-1:0]}, combinational from prog_addr_o.
- instruction_o  out  instruction_t  to ICU; opcode in RUN, NOPO otherwise.
- io_addr_o  out  IO_W  operand[IO_W-1:0] in RUN, 0 otherwise.
- jmp_i, rtn_i, flag_o_i, flag_f_i  in  1 each  ICU decode strobes for the instruction at the current PC.
- running_o  out  1  state == RUN.
- halted_o  out  1  state == HALTED.
- sync_o  out  1  registered one-cycle pulse per executed NOPO.
- stack_err_o  out  1  sticky; overflow or underflow seen.

Behaviour:
- Reset (async, rst_n low): state=IDLE, PC=0, stack empty (sp=0), sync_o=0, stack_err_o=0. Outputs are valid during reset: instruction_o=NOPO, io_addr_o=0.
- States: IDLE, RUN, HALTED.
  - IDLE -> RUN on start_i. PC unchanged (0 after reset).
  - RUN -> HALTED on stop_i, or on flag_f_i. NOPF halts after its own cycle, with PC <= PC+1.
  - HALTED -> RUN on start_i, resuming at the current PC. Stack is preserved.
  - stop_i has priority over start_i.
- Per-cycle PC update in RUN, sampled at posedge. ICU strobes for word at PC are valid before the edge. Priority order:
  1. jmp_i: push PC+1 (mod 2^ADDR_W), then PC <= operand.
  2. rtn_i: pop, PC <= popped value.
  3. Otherwise PC <= PC+1.
- Overflow: JMP with stack full. The jump is still taken, the push is discarded, and stack_err_o is set.
- Underflow: RTN with stack empty. PC <= 0 and stack_err_o is set.
- stack_err_o clears only on reset.
- Stop or flag_f in the same cycle as jmp/rtn: the jump/return completes, then the state moves to HALTED.
- PC wrap: PC = 2^ADDR_W-1 with a plain instruction goes to 0.
- sync_o is 1 for the cycle after a RUN cycle with flag_o_i=1.
- Outside RUN, strobes are ignored and the PC is frozen.
- Skip after RTN/SKZ is handled by the ICU. The sequencer still advances the PC normally.

Optional Feature:
- SINGLE_STEP_EN defined:
  - Adds input step_i and a STEP state.
  - start_i while step_i is high enters STEP instead of RUN.
  - In STEP, each rising edge of step_i (edge-detected internally) executes exactly one word as in RUN. instruction_o is NOPO in all other cycles.
  - start_i with step_i low enters RUN. stop_i enters HALTED.
- Undefined: no step_i port and no STEP state.

Decomposition:
- Shared package instructions:
  - instruction_t: 4-bit enum NOPO=0, LD, LDC, AND, ANDC, OR, ORC, XNOR, STO, STOC, IEN, OEN, JMP, RTN, SKZ, NOPF=15.
  - New seq_state_t: IDLE, RUN, HALTED, STEP.
- Sub-module return_stack (params WIDTH, DEPTH):
  - Inputs push, pop, din.
  - Outputs dout, full, empty.
  - LIFO with registered sp.

Test Plan:
- Reset, start, ROM of plain LD words: PC 0,1,2,3 on consecutive cycles; instruction_o=LD; io_addr_o = operand[2:0].
- Call/return: JMP 0x40 at 0x05, RTN at 0x40 -> PC goes 0x05, 0x40, 0x06. Stack empty afterwards; stack_err_o=0.
- Five nested JMPs with STACK_DEPTH=4 -> fifth jump taken, stack_err_o=1. RTN on empty stack -> PC=0.
- NOPF at 0x10 -> halted_o=1, PC frozen at 0x11, instruction_o=NOPO. start_i resumes at 0x11.
- NOPO at 0x03 -> sync_o high exactly one cycle. PC at 0xFF with plain word -> PC 0x00.
- rst_n low mid-RUN with PC=0x22 and stack depth 2 -> immediate IDLE, PC=0, stack empty.
- With SINGLE_STEP_EN: three step_i pulses -> exactly three PC advances.
